// File: rtl/uart_rx_buffer.sv
// ---------------------------------------------------------------------------
// uart_rx_buffer
//
// Purpose:
//   Receive side of the UART path. An 8N1 deserialiser samples the serial rx
//   line and pushes each good byte into a small circular FIFO. The host
//   drains that FIFO with a read-enable handshake and full/empty flags.
//
// Ports:
//   clk        in   buffer clock; everything runs on the rising edge
//   reset      in   asynchronous, active-low reset
//   rx         in   asynchronous serial line, idles high
//   rd_en      in   pop one byte from the FIFO (ignored while empty)
//   dout       out  byte popped by the last accepted rd_en (held otherwise)
//   full       out  FIFO holds DEPTH entries
//   empty      out  FIFO holds no entries
//   count      out  current FIFO occupancy
//   frame_err  out  one-cycle pulse: stop bit sampled low, byte dropped
//   overrun    out  one-cycle pulse: good byte dropped because FIFO was full
// ---------------------------------------------------------------------------
module uart_rx_buffer #(
    parameter int CLKS_PER_BIT = 27,
    parameter int DEPTH        = 16,
    parameter int ADDR_W       = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rx,
    input  logic              rd_en,
    output logic [7:0]        dout,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   count,
    output logic              frame_err,
    output logic              overrun
);

    // Bit-timing counter must hold CLKS_PER_BIT-1.
    localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;

    // Start bit is re-checked half a bit after the falling edge so that all
    // later samples land near the middle of each bit cell.
    localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'((CLKS_PER_BIT - 1) / 2);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [ADDR_W:0]  DEPTH_CNT = (ADDR_W + 1)'(DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } rx_state_t;

    // -----------------------------------------------------------------------
    // State and storage
    // -----------------------------------------------------------------------
    logic             rx_meta_q, rx_meta_d;
    logic             rx_s_q,    rx_s_d;
    logic             rx_prev_q, rx_prev_d;

    rx_state_t        state_q,   state_d;
    logic [CNT_W-1:0] clk_cnt_q, clk_cnt_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shift_q,   shift_d;

    logic [ADDR_W:0]  wr_ptr_q,  wr_ptr_d;
    logic [ADDR_W:0]  rd_ptr_q,  rd_ptr_d;
    logic [7:0]       dout_q,    dout_d;
    logic             frame_err_q, frame_err_d;
    logic             overrun_q,   overrun_d;

    logic [7:0]       mem [DEPTH];

    // FSM-to-FIFO handshake and FIFO status
    logic             stop_good;
    logic             push;
    logic             pop;
    logic [ADDR_W:0]  occupancy;
    logic             fifo_full;
    logic             fifo_empty;

    // -----------------------------------------------------------------------
    // Two-flop synchroniser plus one history flop for falling-edge detection.
    // Everything downstream looks at rx_s_q only, never at raw rx.
    // -----------------------------------------------------------------------
    always_comb begin
        rx_meta_d = rx;
        rx_s_d    = rx_meta_q;
        rx_prev_d = rx_s_q;
    end

    // -----------------------------------------------------------------------
    // Receive FSM: next state, bit timing and shift register.
    // stop_good flags a stop bit sampled high; the FIFO logic decides whether
    // that becomes a push or an overrun.
    // -----------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        clk_cnt_d   = clk_cnt_q;
        bit_idx_d   = bit_idx_q;
        shift_d     = shift_q;
        stop_good   = 1'b0;
        frame_err_d = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (rx_prev_q && !rx_s_q) begin
                    clk_cnt_d = '0;
                    state_d   = START;
                end
            end

            START: begin
                if (clk_cnt_q == HALF_CNT) begin
                    clk_cnt_d = '0;
                    // A line back high by mid-start was a glitch.
                    if (!rx_s_q) begin
                        bit_idx_d = 3'd0;
                        state_d   = DATA;
                    end else begin
                        state_d   = IDLE;
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + 1'b1;
                end
            end

            DATA: begin
                if (clk_cnt_q == FULL_CNT) begin
                    clk_cnt_d          = '0;
                    shift_d[bit_idx_q] = rx_s_q;
                    if (bit_idx_q == 3'd7) begin
                        state_d = STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 1'b1;
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + 1'b1;
                end
            end

            STOP: begin
                if (clk_cnt_q == FULL_CNT) begin
                    clk_cnt_d = '0;
                    state_d   = IDLE;
                    if (rx_s_q) begin
                        stop_good = 1'b1;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + 1'b1;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // FIFO control. Pointers carry one extra wrap bit so full and empty are
    // distinguishable by a plain subtraction. A pop frees a slot in the same
    // cycle, so a push while full still succeeds if the host is reading.
    // A pop while empty is ignored even when a push lands that cycle.
    // -----------------------------------------------------------------------
    always_comb begin
        occupancy  = wr_ptr_q - rd_ptr_q;
        fifo_full  = (occupancy == DEPTH_CNT);
        fifo_empty = (occupancy == '0);

        pop       = rd_en && !fifo_empty;
        push      = stop_good && (!fifo_full || pop);
        overrun_d = stop_good && !push;

        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        dout_d   = dout_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
            dout_d   = mem[rd_ptr_q[ADDR_W-1:0]];
        end
    end

    // -----------------------------------------------------------------------
    // Register bank. Synchroniser flops reset to the idle line level so that
    // leaving reset never looks like a start edge.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_meta_q   <= 1'b1;
            rx_s_q      <= 1'b1;
            rx_prev_q   <= 1'b1;
            state_q     <= IDLE;
            clk_cnt_q   <= '0;
            bit_idx_q   <= 3'd0;
            shift_q     <= 8'h00;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            dout_q      <= 8'h00;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            rx_meta_q   <= rx_meta_d;
            rx_s_q      <= rx_s_d;
            rx_prev_q   <= rx_prev_d;
            state_q     <= state_d;
            clk_cnt_q   <= clk_cnt_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            dout_q      <= dout_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    // -----------------------------------------------------------------------
    // Byte storage. No reset needed: an entry is only read after it has been
    // written. A simultaneous push and pop at the same slot (full FIFO) reads
    // the old contents because the read above uses pre-edge memory.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q[ADDR_W-1:0]] <= shift_q;
        end
    end

    assign dout      = dout_q;
    assign full      = fifo_full;
    assign empty     = fifo_empty;
    assign count     = occupancy;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;

endmodule

// File: doc/uart_rx_buffer.md
Name: uart_rx_buffer

Overview:
- Receive-side counterpart of the TX FIFO path: a UART 8N1 deserialiser feeding an internal byte FIFO.
- Sits between the serial rx pin and the host logic. The host drains received bytes with the same wr/rd-style handshake and full/empty flags as the TX buffer.
- Runs on the single 3.125 MHz buffer clock.

Parameters:
- CLKS_PER_BIT, 27, clock cycles per UART bit (3.125 MHz / 115200 baud).
- DEPTH, 16, FIFO entries (power of two).
- ADDR_W, 4, log2(DEPTH).

Ports:
- clk  input  1  3.125 MHz clock; all logic on rising edge.
- reset  input  1  asynchronous, active-low reset.
- rx  input  1  asynchronous serial line; idles high.
- rd_en  input  1  pop one byte from the FIFO.
- dout  output  8  byte popped by the last accepted rd_en.
- full  output  1  FIFO holds DEPTH entries.
- empty  output  1  FIFO holds 0 entries.
- count  output  ADDR_W+1  current FIFO occupancy.
- frame_err  output  1  one-cycle pulse: stop bit sampled low.
- overrun  output  1  one-cycle pulse: received byte dropped because FIFO full.

Behaviour:
- Reset (reset=0, async):
  - Outputs: dout=0x00, full=0, empty=1, count=0, frame_err=0, overrun=0.
  - Internal: FSM=IDLE, bit/clk counters 0, pointers 0, rx synchroniser flops set to 1.
  - Reset mid-frame discards the partial byte.
- Input synchronisation: rx passes through 2 flops (rx_s). Detection is done on rx_s only.
- FSM states are IDLE, START, DATA, STOP.
  - IDLE: a falling edge on rx_s (previous 1, current 0) clears the clk counter and moves to START.
  - START: counts to (CLKS_PER_BIT-1)/2 = 13, then samples rx_s.
    - Sample = 0: clear the counter and go to DATA with bit index 0.
    - Sample = 1: false start; return to IDLE. No flags.
  - DATA: counts CLKS_PER_BIT-1, then samples rx_s into shift register bit[index], LSB first.
    - After index 7, go to STOP; otherwise index+1.
  - STOP: counts CLKS_PER_BIT-1, then samples rx_s.
    - Sample = 1 and FIFO accepts: push the byte.
    - Sample = 1 and FIFO does not accept: pulse overrun for 1 cycle; byte dropped.
    - Sample = 0: pulse frame_err for 1 cycle; byte dropped.
    - In every case return to IDLE in the same cycle. The next start needs a fresh falling edge, so a line stuck low after a framing error produces no further bytes.
- Latency: the byte is visible (empty falls, count increments) on the cycle after the stop-bit mid-sample edge. That is about 9.5 bit times plus 3 cycles after the start-bit falling edge on rx.
- FIFO:
  - Circular buffer with ADDR_W+1-bit pointers.
  - full/empty/count are derived from the pointers and are registered-accurate the cycle after each push/pop.
  - Pop: rd_en=1 with empty=0 registers mem[rd_ptr] into dout on that edge and advances rd_ptr.
  - rd_en while empty is ignored; dout holds its value.
  - dout holds the last popped value indefinitely.
  - Push and pop in the same cycle:
    - Both occur; count unchanged.
    - A push while full is accepted if rd_en pops in the same cycle, with no overrun.
    - With empty=1, a push and an rd_en in the same cycle give push only; the pop is ignored.
  - Pointers wrap modulo DEPTH. Ordering is strict FIFO across wrap.
- frame_err and overrun are mutually exclusive and never assert outside STOP-exit cycles.

Test Plan:
- Byte receive: after reset, drive 0xA5 on rx at 27 clk/bit (start 0, LSB first, stop 1).
  - Required: empty=0 and count=1 after the stop mid-sample; no flags.
  - Then rd_en for 1 cycle → dout=0xA5, empty=1, count=0.
- Glitch reject: rx low for 5 cycles, then high for 300 cycles → FSM returns to IDLE; count=0, empty=1, no flags.
- Framing error: send 0x3C with stop bit driven 0 → frame_err high exactly 1 cycle; count stays 0. A following valid 0x55 → count=1, dout=0x55 on read.
- Fill/overrun/wrap:
  - Send bytes 0x00..0x0F with no reads → full=1, count=16.
  - 17th byte 0x10 → overrun 1-cycle pulse; count stays 16.
  - Read 16 times → 0x00..0x0F in order, then empty=1.
  - Repeat with 0x20..0x2F to verify pointer wrap.
- Simultaneous push/pop at full: with FIFO full, assert rd_en on the push cycle of a new byte 0x99 → no overrun; count stays 16; 0x99 emerges last.
- Reset mid-frame: assert reset during DATA bit 4 of 0xF0, then release → all outputs at reset values. A subsequent 0x81 is received correctly, and count=1.
